perip_adsr_env: RTL and testbench

Memory-mapped ADSR envelope generator for the synthesizer datapath. It sits directly upstream of the LED/tone PWM peripheral: its `level` output drives that block's 32-bit duty/frequency input. It converts a key gate, from the keyboard or from a CPU soft-gate bit, into an attack/decay/sustain/release amplitude ramp. Step sizes and the sustain level are programmed over the same simple cs/rd/wr CPU bus.

---
 rtl/perip_adsr_env_pkg.sv | 26 ++
 rtl/perip_adsr_env_core.sv | 124 ++++++++++++
 rtl/perip_adsr_env.sv | 109 ++++++++++
 tb/tb_perip_adsr_env.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/perip_adsr_env_pkg.sv
// Shared definitions for the ADSR envelope peripheral: register offsets,
// FSM state encodings and STATUS field positions.
package perip_adsr_env_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_ATTACK  = 5'h04;
  localparam logic [4:0] REG_DECAY   = 5'h08;
  localparam logic [4:0] REG_SUSTAIN = 5'h0C;
  localparam logic [4:0] REG_RELEASE = 5'h10;
  localparam logic [4:0] REG_STATUS  = 5'h14;
  localparam logic [4:0] REG_LEVEL   = 5'h18;

  localparam int CTRL_GATE_BIT    = 0;
  localparam int CTRL_RETRIG_BIT  = 1;
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_W   = 3;

endpackage

// File: rtl/perip_adsr_env_core.sv
// adsr_core: tick prescaler, gate edge detect, ADSR FSM and level arithmetic.
// Optional macro ADSR_GATE_SYNC_EN adds a 2-flop synchronizer on gate_in.
module adsr_core
  import perip_adsr_env_pkg::*;
#(
  parameter int LEVEL_W  = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gate_in,
  input  logic               soft_gate,
  input  logic               retrig,
  input  logic [LEVEL_W-1:0] attack_step,
  input  logic [LEVEL_W-1:0] decay_step,
  input  logic [LEVEL_W-1:0] sustain_lvl,
  input  logic [LEVEL_W-1:0] release_step,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         state,
  output logic               active
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_RELOAD = PW'(TICK_DIV - 1);
  localparam logic [LEVEL_W:0] MAX_X        = {1'b0, {LEVEL_W{1'b1}}};

  logic gate_s;
`ifdef ADSR_GATE_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  always_comb begin
    sync1_d = gate_in;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign gate_s = sync2_q;
`else
  assign gate_s = gate_in;
`endif

  logic                g, trig, tick;
  logic                g_prev_q, g_prev_d;
  logic [PW-1:0]       presc_q, presc_d;
  adsr_state_e         state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                active_q, active_d;
  logic [LEVEL_W:0]    lvl_x, att_sum, dec_floor;

  always_comb begin
    g         = gate_s | soft_gate;
    trig      = (g & ~g_prev_q) | retrig;
    tick      = (presc_q == '0);
    g_prev_d  = g;
    presc_d   = (trig || tick) ? PRESC_RELOAD : presc_q - PW'(1);
    lvl_x     = {1'b0, level_q};
    att_sum   = lvl_x + {1'b0, attack_step};
    dec_floor = {1'b0, sustain_lvl} + {1'b0, decay_step};
    state_d   = state_q;
    level_d   = level_q;
    // trigger beats a falling gate and any tick in the same cycle
    if (trig) begin
      state_d = ST_ATTACK;
    end else if (!g && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      state_d = ST_RELEASE;
    end else if (tick) begin
      case (state_q)
        ST_ATTACK: begin
          if (attack_step == '0 || att_sum >= MAX_X) begin
            level_d = '1;
            state_d = ST_DECAY;
          end else begin
            level_d = att_sum[LEVEL_W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_step == '0 || lvl_x <= dec_floor) begin
            level_d = sustain_lvl;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - decay_step;
          end
        end
        ST_SUSTAIN: level_d = sustain_lvl;
        ST_RELEASE: begin
          if (release_step == '0 || lvl_x <= {1'b0, release_step}) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - release_step;
          end
        end
        default: ;
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_prev_q <= 1'b0;
      presc_q  <= '0;
      state_q  <= ST_IDLE;
      level_q  <= '0;
      active_q <= 1'b0;
    end else begin
      g_prev_q <= g_prev_d;
      presc_q  <= presc_d;
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= active_d;
    end
  end

  assign level  = level_q;
  assign state  = state_q;
  assign active = active_q;

endmodule

// File: rtl/perip_adsr_env.sv
// Memory-mapped ADSR envelope generator: bus decode and config registers.
// Build option: define ADSR_GATE_SYNC_EN to synchronize gate_in (see adsr_core).
module perip_adsr_env
  import perip_adsr_env_pkg::*;
#(
  parameter int LEVEL_W  = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  input  logic        gate_in,
  output logic [31:0] level,
  output logic        active
);
  logic               ctrl_gate_q, ctrl_gate_d;
  logic               retrig_q, retrig_d;
  logic [LEVEL_W-1:0] attack_q, attack_d, decay_q, decay_d;
  logic [LEVEL_W-1:0] sustain_q, sustain_d, release_q, release_d;
  logic [31:0]        d_out_q, d_out_d, rd_data;
  logic [LEVEL_W-1:0] core_level;
  logic [2:0]         core_state;
  logic [4:0]         a;
  logic               unused_bits;

  assign unused_bits = ^{addr[31:5], d_in[31:LEVEL_W]};

  always_comb begin
    a           = addr[4:0];
    ctrl_gate_d = ctrl_gate_q;
    retrig_d    = 1'b0;
    attack_d    = attack_q;
    decay_d     = decay_q;
    sustain_d   = sustain_q;
    release_d   = release_q;
    if (cs && wr) begin
      case (a)
        REG_CTRL: begin
          ctrl_gate_d = d_in[CTRL_GATE_BIT];
          retrig_d    = d_in[CTRL_RETRIG_BIT];
        end
        REG_ATTACK:  attack_d  = d_in[LEVEL_W-1:0];
        REG_DECAY:   decay_d   = d_in[LEVEL_W-1:0];
        REG_SUSTAIN: sustain_d = d_in[LEVEL_W-1:0];
        REG_RELEASE: release_d = d_in[LEVEL_W-1:0];
        default: ;
      endcase
    end
    rd_data = '0;
    case (a)
      REG_CTRL:    rd_data[CTRL_GATE_BIT] = ctrl_gate_q;
      REG_ATTACK:  rd_data = 32'(attack_q);
      REG_DECAY:   rd_data = 32'(decay_q);
      REG_SUSTAIN: rd_data = 32'(sustain_q);
      REG_RELEASE: rd_data = 32'(release_q);
      REG_STATUS:  rd_data[STATUS_STATE_LSB +: STATUS_STATE_W] = core_state;
      REG_LEVEL:   rd_data = 32'(core_level);
      default: ;
    endcase
    d_out_d = (cs && rd) ? rd_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_gate_q <= 1'b0;
      retrig_q    <= 1'b0;
      attack_q    <= '0;
      decay_q     <= '0;
      sustain_q   <= '0;
      release_q   <= '0;
      d_out_q     <= '0;
    end else begin
      ctrl_gate_q <= ctrl_gate_d;
      retrig_q    <= retrig_d;
      attack_q    <= attack_d;
      decay_q     <= decay_d;
      sustain_q   <= sustain_d;
      release_q   <= release_d;
      d_out_q     <= d_out_d;
    end
  end

  adsr_core #(
    .LEVEL_W  (LEVEL_W),
    .TICK_DIV (TICK_DIV)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .gate_in      (gate_in),
    .soft_gate    (ctrl_gate_q),
    .retrig       (retrig_q),
    .attack_step  (attack_q),
    .decay_step   (decay_q),
    .sustain_lvl  (sustain_q),
    .release_step (release_q),
    .level        (core_level),
    .state        (core_state),
    .active       (active)
  );

  assign d_out = d_out_q;
  assign level = 32'(core_level);

endmodule

// File: tb/tb_perip_adsr_env.sv
// Directed scoreboard bench for perip_adsr_env (TICK_DIV=4, LEVEL_W=16).
module tb_perip_adsr_env;
  localparam int TD = 4;
`ifdef ADSR_GATE_SYNC_EN
  localparam int GATE_LAT = 3;
`else
  localparam int GATE_LAT = 1;
`endif

  localparam logic [31:0] S1_LVL [12] = '{32'h4000, 32'h8000, 32'hC000, 32'hFFFF,
                                          32'hEFFF, 32'hDFFF, 32'hCFFF, 32'hBFFF,
                                          32'hAFFF, 32'h9FFF, 32'h8FFF, 32'h8000};
  localparam logic [2:0]  S1_ST  [12] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                                          3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
  localparam logic [31:0] S2_LVL [4]  = '{32'h6000, 32'h4000, 32'h2000, 32'h0};
  localparam logic [2:0]  S2_ST  [4]  = '{3'd4, 3'd4, 3'd4, 3'd0};

  logic        clk = 1'b0, reset = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, gate_in = 1'b0;
  logic [31:0] d_in = '0, addr = '0;
  logic [31:0] d_out, level;
  logic        active;

  int cyc = 0;
  int n_vec = 0, n_bad = 0;
  int base, kn, lat;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  perip_adsr_env #(.LEVEL_W(16), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_in    (d_in),
    .cs      (cs),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .d_out   (d_out),
    .gate_in (gate_in),
    .level   (level),
    .active  (active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_v(input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL scoreboard_empty: got %h want <queued entry>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_vec++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    step();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string t);
    expect_v(e, t);
    cs = 1'b1; rd = 1'b1; addr = a;
    step();
    cs = 1'b0; rd = 1'b0;
    observe(d_out);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    if (cyc > n) begin
      n_bad++;
      $error("FAIL schedule: at cycle %0d want %0d", cyc, n);
    end
    while (cyc < n && guard < 2000) begin
      step();
      guard++;
    end
  endtask

  // level on the tick edge, then state via STATUS on the following edge
  task automatic check_tick(input int k, input logic [31:0] lvl, input logic [2:0] st,
                            input string t);
    wait_cyc(base + TD * k);
    expect_v(lvl, {t, "_level"});
    observe(level);
    bus_read(32'h14, {29'd0, st}, {t, "_state"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    expect_v(32'h0, "rst_dout");   observe(d_out);
    expect_v(32'h0, "rst_level");  observe(level);
    expect_v(32'h0, "rst_active"); observe({31'd0, active});
    reset = 1'b0;
    step();
    bus_read(32'h14, 32'h0, "rst_status");
    bus_read(32'h04, 32'h0, "rst_attack");

    // attack -> decay -> sustain
    bus_write(32'h04, 32'h4000);
    bus_write(32'h08, 32'h1000);
    bus_write(32'h0C, 32'h8000);
    bus_write(32'h00, 32'h1);
    base = cyc + 1;
    wait_cyc(base);
    expect_v(32'h1, "trig_active"); observe({31'd0, active});
    for (int k = 1; k <= 12; k++) check_tick(k, S1_LVL[k-1], S1_ST[k-1], "adsr");

    // release from 0x8000
    bus_write(32'h10, 32'h2000);
    bus_write(32'h00, 32'h0);
    kn = (cyc + 1 - base) / TD + 1;
    for (int i = 0; i < 4; i++) check_tick(kn + i, S2_LVL[i], S2_ST[i], "release");
    expect_v(32'h0, "idle_active"); observe({31'd0, active});

    // gate drop mid-attack, then retrigger at 0x4000
    bus_write(32'h00, 32'h1);
    base = cyc + 1;
    check_tick(1, 32'h4000, 3'd1, "s3_att");
    check_tick(2, 32'h8000, 3'd1, "s3_att");
    bus_write(32'h00, 32'h0);
    kn = (cyc + 1 - base) / TD + 1;
    check_tick(kn,     32'h6000, 3'd4, "drop_rel");
    check_tick(kn + 1, 32'h4000, 3'd4, "drop_rel");
    bus_write(32'h00, 32'h3);
    base = cyc + 1;
    wait_cyc(base);
    expect_v(32'h4000, "retrig_level"); observe(level);
    bus_read(32'h14, 32'h1, "retrig_state");
    check_tick(1, 32'h8000, 3'd1, "resume");
    check_tick(2, 32'hC000, 3'd1, "resume");
    check_tick(3, 32'hFFFF, 3'd2, "saturate");

    // DECAY=0 reaches sustain on the next tick
    bus_write(32'h08, 32'h0);
    check_tick(4, 32'h8000, 3'd3, "decay0");

    // live sustain update
    bus_write(32'h0C, 32'h2000);
    kn = (cyc - base) / TD + 1;
    check_tick(kn, 32'h2000, 3'd3, "sus_live");
    bus_read(32'h18, 32'h2000, "level_reg");
    bus_read(32'h00, 32'h1, "ctrl_rd");

    // retrigger with gate held high
    bus_write(32'h00, 32'h3);
    base = cyc + 1;
    wait_cyc(base);
    expect_v(32'h2000, "retrig2_level"); observe(level);
    bus_read(32'h14, 32'h1, "retrig2_state");
    bus_read(32'h00, 32'h1, "ctrl_retrig_rd");
    check_tick(1, 32'h6000, 3'd1, "retrig2_att");

    // bus corner cases
    bus_read(32'h1C, 32'h0, "unmapped_rd");
    bus_read(32'h14, 32'h1, "status_attack");
    step();
    expect_v(32'h0, "dout_idle"); observe(d_out);
    bus_write(32'h04, 32'h12345678);
    bus_read(32'h04, 32'h00005678, "attack_trunc");

    // reset mid-attack
    reset = 1'b1;
    #1;
    expect_v(32'h0, "midrst_level");  observe(level);
    expect_v(32'h0, "midrst_active"); observe({31'd0, active});
    step();
    reset = 1'b0;
    step();
    bus_read(32'h14, 32'h0, "midrst_state");
    bus_read(32'h04, 32'h0, "midrst_attack");

    // keyboard gate latency, all steps zero
    gate_in = 1'b1;
    lat = 0;
    while (!active && lat < 10) begin
      step();
      lat++;
    end
    expect_v(GATE_LAT, "gate_lat"); observe(lat);
    base = cyc;
    check_tick(1, 32'hFFFF, 3'd2, "att0");
    check_tick(2, 32'h0,    3'd3, "dec0_sus0");
    gate_in = 1'b0;
    kn = (cyc + GATE_LAT - base) / TD + 1;
    check_tick(kn, 32'h0, 3'd0, "rel0");
    expect_v(32'h0, "rel0_active"); observe({31'd0, active});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
